mem_port_arbiter: RTL and testbench

- Shares one unified single-port instruction/data memory between two requesters of the CPU datapath: the instruction-fetch stage (IF) and the load/store unit (D).
- Round-robin arbitration, request/ack handshake toward each requester, enable/ready handshake toward memory.
- Lets the CPU move from split memories to a single memory array; the core stalls on a missing ack.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 38 +++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter:
// FSM state encoding, requester ids and default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Requester ids; also the encoding held in the round-robin last-grant bit
    localparam logic MST_IF = 1'b0;
    localparam logic MST_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant selector for the fetch (IF) and data (D) ports.
// On a tie the requester that did not win last time is chosen; the remembered
// winner starts as D so that IF wins the first tie after reset.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_if,
    input  logic i_req_d,
    input  logic i_update,
    output logic o_valid,
    output logic o_grant
);

    logic r_last;

    // Pick the winner from the current requests and the previous winner
    always_comb begin
        o_valid = i_req_if | i_req_d;
        o_grant = MST_IF;
        if (i_req_if && i_req_d) begin
            o_grant = ~r_last;
        end else if (i_req_d) begin
            o_grant = MST_D;
        end
    end

    // Remember the winner whenever the caller accepts a grant
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= MST_D;
        end else if (i_update) begin
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the instruction fetch stage
// (IF) and the load/store unit (D). Round-robin grant, request/ack toward the
// requesters, enable/ready toward memory. All outputs are registered.
// Optional macro ARB_TIMEOUT_EN adds a BUSY wait counter that aborts an access
// after TIMEOUT_CYC cycles without mem_ready and flags it on bus_err; the
// TIMEOUT_CYC parameter exists only in that build.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_master;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_ack;
    logic              r_d_ack;
    logic              r_bus_err;

    logic              w_gnt_vld;
    logic              w_gnt;
    logic              w_take;
    logic              w_finish;
    logic              w_abort;
    logic              w_timeout;

    rr_arb2 u_rr_arb2 (
        .i_clk    (CLK),
        .i_rst    (Reset),
        .i_req_if (if_req),
        .i_req_d  (d_req),
        .i_update (w_take),
        .o_valid  (w_gnt_vld),
        .o_grant  (w_gnt)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] r_wait_cnt;

    // The abort fires on the BUSY cycle whose missing ready would bring the count to TIMEOUT_CYC
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count BUSY cycles without mem_ready; restart on every grant
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_wait_cnt <= '0;
        end else if (w_take) begin
            r_wait_cnt <= '0;
        end else if ((r_state == BUSY) && !mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the one-cycle grant/complete/abort strobes
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_take      = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            // Requests are ignored here, giving the acked requester a cycle to drop req
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Latch the granted access, drive memory, capture read data and pulse acks
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_master    <= MST_IF;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_ack  <= 1'b0;
            r_d_ack   <= 1'b0;
            r_bus_err <= 1'b0;
            if (w_take) begin
                r_master <= w_gnt;
                r_mem_en <= 1'b1;
                if (w_gnt == MST_D) begin
                    r_mem_we    <= d_we;
                    r_mem_addr  <= d_addr;
                    r_mem_wdata <= d_wdata;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= if_addr;
                    r_mem_wdata <= '0;
                end
            end
            if (w_finish || w_abort) begin
                r_mem_en  <= 1'b0;
                r_mem_we  <= 1'b0;
                r_bus_err <= w_abort;
                if (r_master == MST_IF) begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= w_abort ? '0 : mem_rdata;
                end else begin
                    r_d_ack <= 1'b1;
                    if (w_abort) begin
                        r_d_rdata <= '0;
                    end else if (!r_mem_we) begin
                        r_d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ack    = r_if_ack;
    assign d_rdata   = r_d_rdata;
    assign d_ack     = r_d_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (default build, no timeout feature).
// Directed table of cycles, hand-written multi-cycle sequences, then random
// traffic checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        rdy;
        logic [31:0] rd;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_ia;
        logic        e_da;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    vec_t tbl [13];

    logic [31:0] mem_m [logic [31:0]];

    logic [31:0] exp_ird;
    logic [31:0] exp_drd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic row(input int i, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                       input logic rdy, input logic [31:0] rd,
                       input logic een, input logic ewe, input logic [31:0] ea, input logic [31:0] ewd,
                       input logic eia, input logic eda, input logic [31:0] eird, input logic [31:0] edrd);
        tbl[i] = '{ir, ia, dr, dw, da, dwd, rdy, rd, een, ewe, ea, ewd, eia, eda, eird, edrd};
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A00_F00D;
    endfunction

    task automatic idle_inputs();
        if_req    = 1'b0; if_addr = '0;
        d_req     = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, " en"}, 32'(mem_en), 32'd0);
        chk({name, " if_ack"}, 32'(if_ack), 32'd0);
        chk({name, " d_ack"}, 32'(d_ack), 32'd0);
    endtask

    // random-phase model state
    logic        m_last;
    logic        cur_mst;
    logic [31:0] cur_addr;
    logic        cur_we;
    logic [31:0] cur_wd;
    int          wait_left;
    logic        if_pend, d_pend;
    logic        s_if, s_d, s_dwe, s_rdy, s_en, s_ack;
    logic [31:0] s_ia, s_da, s_dwd, s_rd;
    logic        win;

    initial begin
        idle_inputs();
        Reset = 1'b1;
        step();
        step();
        // reset state
        chk("rst en", 32'(mem_en), 32'd0);
        chk("rst we", 32'(mem_we), 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        chk("rst if_ack", 32'(if_ack), 32'd0);
        chk("rst d_ack", 32'(d_ack), 32'd0);
        chk("rst if_rdata", if_rdata, 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        Reset = 1'b0;

        //  i  ir    ia      dr    dw    da      dwd            rdy   rd             en    we    addr    wdata          ia    da    ird            drd
        row(0, 1'b1, 32'h4,  1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h4,  32'h0,         1'b0, 1'b0, 32'h0,         32'h0);
        row(1, 1'b1, 32'h4,  1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 32'h2002_0001, 1'b0, 1'b0, 32'h4,  32'h0,         1'b1, 1'b0, 32'h2002_0001, 32'h0);
        row(2, 1'b0, 32'h4,  1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h2002_0001, 32'h0);
        row(3, 1'b1, 32'h4,  1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 1'b0, 32'h2002_0001, 32'h0);
        row(4, 1'b1, 32'h4,  1'b1, 1'b0, 32'h20, 32'h0,         1'b1, 32'h1111,      1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'h2002_0001, 32'h1111);
        row(5, 1'b1, 32'h4,  1'b0, 1'b0, 32'h20, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h2002_0001, 32'h1111);
        row(6, 1'b1, 32'h4,  1'b1, 1'b1, 32'h30, 32'hCAFE_0000, 1'b0, 32'h0,         1'b1, 1'b0, 32'h4,  32'h0,         1'b0, 1'b0, 32'h2002_0001, 32'h1111);
        row(7, 1'b1, 32'h4,  1'b1, 1'b1, 32'h30, 32'hCAFE_0000, 1'b1, 32'h33,        1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h33,        32'h1111);
        row(8, 1'b0, 32'h4,  1'b1, 1'b1, 32'h30, 32'hCAFE_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h33,        32'h1111);
        row(9, 1'b0, 32'h4,  1'b1, 1'b1, 32'h30, 32'hCAFE_0000, 1'b0, 32'h0,         1'b1, 1'b1, 32'h30, 32'hCAFE_0000, 1'b0, 1'b0, 32'h33,        32'h1111);
        row(10, 1'b0, 32'h4, 1'b1, 1'b1, 32'h30, 32'hCAFE_0000, 1'b1, 32'h9999_9999, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'h33,        32'h1111);
        row(11, 1'b0, 32'h4, 1'b0, 1'b0, 32'h30, 32'h0,         1'b1, 32'h77,        1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h33,        32'h1111);
        row(12, 1'b0, 32'h4, 1'b0, 1'b0, 32'h30, 32'h0,         1'b1, 32'h55,        1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h33,        32'h1111);

        for (int i = 0; i < 13; i++) begin
            if_req = tbl[i].ir;  if_addr = tbl[i].ia;
            d_req = tbl[i].dr;   d_we = tbl[i].dw; d_addr = tbl[i].da; d_wdata = tbl[i].dwd;
            mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rd;
            step();
            chk($sformatf("row%0d en", i), 32'(mem_en), 32'(tbl[i].e_en));
            chk($sformatf("row%0d we", i), 32'(mem_we), 32'(tbl[i].e_we));
            if (tbl[i].e_en) chk($sformatf("row%0d addr", i), mem_addr, tbl[i].e_addr);
            if (tbl[i].e_en && tbl[i].e_we) chk($sformatf("row%0d wdata", i), mem_wdata, tbl[i].e_wd);
            chk($sformatf("row%0d if_ack", i), 32'(if_ack), 32'(tbl[i].e_ia));
            chk($sformatf("row%0d d_ack", i), 32'(d_ack), 32'(tbl[i].e_da));
            chk($sformatf("row%0d if_rdata", i), if_rdata, tbl[i].e_ird);
            chk($sformatf("row%0d d_rdata", i), d_rdata, tbl[i].e_drd);
            chk($sformatf("row%0d bus_err", i), 32'(bus_err), 32'd0);
        end
        exp_ird = 32'h33;
        exp_drd = 32'h1111;

        // store with three wait states
        idle_inputs();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        step();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("st c%0d en", c), 32'(mem_en), 32'd1);
            chk($sformatf("st c%0d we", c), 32'(mem_we), 32'd1);
            chk($sformatf("st c%0d addr", c), mem_addr, 32'h10);
            chk($sformatf("st c%0d wdata", c), mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("st c%0d d_ack", c), 32'(d_ack), 32'd0);
            mem_ready = (c == 4);
            mem_rdata = 32'hBAD0_BAD0;
            step();
        end
        chk("st ack", 32'(d_ack), 32'd1);
        chk("st en drop", 32'(mem_en), 32'd0);
        chk("st d_rdata", d_rdata, exp_drd);
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        step();
        chk_quiet("st idle");

        // reset in the middle of a load
        d_req = 1'b1; d_addr = 32'h40;
        step();
        chk("rmid en", 32'(mem_en), 32'd1);
        #3;
        Reset = 1'b1;
        #1;
        chk("rmid async en", 32'(mem_en), 32'd0);
        chk("rmid d_rdata", d_rdata, 32'd0);
        step();
        chk("rmid d_ack", 32'(d_ack), 32'd0);
        Reset = 1'b0;
        exp_ird = '0;
        exp_drd = '0;
        if_req = 1'b1; if_addr = 32'h8;
        step();
        chk("rmid grant en", 32'(mem_en), 32'd1);
        chk("rmid grant IF first", mem_addr, 32'h8);
        mem_ready = 1'b1; mem_rdata = 32'hABCD;
        step();
        chk("rmid if_ack", 32'(if_ack), 32'd1);
        chk("rmid no d_ack", 32'(d_ack), 32'd0);
        chk("rmid if_rdata", if_rdata, 32'hABCD);
        exp_ird = 32'hABCD;
        if_req = 1'b0; mem_ready = 1'b0;
        step();
        chk_quiet("rmid done");
        step();
        chk("rmid D en", 32'(mem_en), 32'd1);
        chk("rmid D addr", mem_addr, 32'h40);
        mem_ready = 1'b1; mem_rdata = 32'h4444;
        step();
        chk("rmid D ack", 32'(d_ack), 32'd1);
        chk("rmid D rdata", d_rdata, 32'h4444);
        exp_drd = 32'h4444;
        d_req = 1'b0; mem_ready = 1'b0;
        step();
        chk_quiet("rmid idle");

        // requester holds req through DONE, drops it in the following cycle
        if_req = 1'b1; if_addr = 32'hC;
        step();
        mem_ready = 1'b1; mem_rdata = 32'hC0C0;
        step();
        chk("hold ack", 32'(if_ack), 32'd1);
        chk("hold rdata", if_rdata, 32'hC0C0);
        exp_ird = 32'hC0C0;
        mem_ready = 1'b0;
        step();
        chk_quiet("hold idle");
        if_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_quiet($sformatf("hold after%0d", c));
        end

        // request dropped before ack still completes
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        step();
        chk("drop en", 32'(mem_en), 32'd1);
        d_req = 1'b0;
        step();
        chk("drop en held", 32'(mem_en), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h5050;
        step();
        chk("drop ack", 32'(d_ack), 32'd1);
        chk("drop rdata", d_rdata, 32'h5050);
        exp_drd = 32'h5050;
        mem_ready = 1'b0;
        step();
        chk_quiet("drop idle");

        // random traffic against the arbitration model
        m_last = 1'b1;
        if_pend = 1'b0;
        d_pend = 1'b0;
        wait_left = 0;
        cur_mst = 1'b0; cur_addr = '0; cur_we = 1'b0; cur_wd = '0;
        for (int k = 0; k < 2000; k++) begin
            if (!if_pend && ($urandom_range(0, 2) == 0)) begin
                if_pend = 1'b1;
                if_addr = 32'($urandom_range(0, 7)) << 2;
            end
            if (!d_pend && ($urandom_range(0, 2) == 0)) begin
                d_pend  = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'($urandom_range(0, 7)) << 2;
                d_wdata = $urandom();
            end
            if_req = if_pend;
            d_req  = d_pend;
            if (mem_en) begin
                mem_ready = (wait_left == 0);
                mem_rdata = (mem_ready && !cur_we) ? mem_rd(cur_addr) : $urandom();
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom();
            end
            s_if = if_req; s_ia = if_addr;
            s_d = d_req; s_dwe = d_we; s_da = d_addr; s_dwd = d_wdata;
            s_rdy = mem_ready; s_rd = mem_rdata;
            s_en = mem_en; s_ack = if_ack | d_ack;
            step();
            if (s_en && s_rdy) begin
                chk("rnd done en", 32'(mem_en), 32'd0);
                chk("rnd done we", 32'(mem_we), 32'd0);
                chk("rnd if_ack", 32'(if_ack), 32'(cur_mst == 1'b0));
                chk("rnd d_ack", 32'(d_ack), 32'(cur_mst == 1'b1));
                if (cur_mst == 1'b0) begin
                    exp_ird = s_rd;
                    if_pend = 1'b0;
                end else begin
                    if (cur_we) mem_m[cur_addr] = cur_wd;
                    else        exp_drd = s_rd;
                    d_pend = 1'b0;
                end
            end else if (s_en) begin
                chk("rnd busy en", 32'(mem_en), 32'd1);
                chk("rnd busy we", 32'(mem_we), 32'(cur_we));
                chk("rnd busy addr", mem_addr, cur_addr);
                if (cur_we) chk("rnd busy wdata", mem_wdata, cur_wd);
                chk("rnd busy acks", 32'(if_ack | d_ack), 32'd0);
                wait_left--;
            end else if (s_ack) begin
                chk_quiet("rnd done cycle");
            end else if (s_if || s_d) begin
                win = (s_if && s_d) ? ~m_last : s_d;
                m_last   = win;
                cur_mst  = win;
                cur_addr = win ? s_da : s_ia;
                cur_we   = win & s_dwe;
                cur_wd   = s_dwd;
                wait_left = $urandom_range(0, 3);
                chk("rnd grant en", 32'(mem_en), 32'd1);
                chk("rnd grant addr", mem_addr, cur_addr);
                chk("rnd grant we", 32'(mem_we), 32'(cur_we));
                if (cur_we) chk("rnd grant wdata", mem_wdata, cur_wd);
                chk("rnd grant acks", 32'(if_ack | d_ack), 32'd0);
            end else begin
                chk_quiet("rnd idle");
            end
            chk("rnd if_rdata", if_rdata, exp_ird);
            chk("rnd d_rdata", d_rdata, exp_drd);
            chk("rnd bus_err", 32'(bus_err), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
